// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//
// Purpose:
//   Chooses one ALU operand from four sources: the sign-extended program
//   counter, a register-file value, an extended immediate, or a forwarded ALU
//   result. The operand is extended to DATA_W and captured into a two-entry
//   elastic buffer, made of an output register and a skid register. The
//   buffer gives full throughput under valid/ready handshaking. The ready and
//   valid outputs come straight from state flops, so they have no
//   combinational path from in_valid or out_ready.
//
// Parameters:
//   DATA_W     operand width
//   PC_W       program-counter width   (must be <= DATA_W)
//   IMM_W      immediate width         (must be <= DATA_W)
//
// Ports:
//   clock      in   1       single clock; all state changes on posedge
//   reset_n    in   1       asynchronous active-low reset
//   in_valid   in   1       upstream operand request valid
//   in_ready   out  1       block can accept a request (registered)
//   sel        in   2       source select: 00 pc, 01 reg_a, 10 imm, 11 fwd
//   imm_signed in   1       1 = sign-extend imm, 0 = zero-extend imm
//   reg_a      in   DATA_W  register-file operand
//   pc         in   PC_W    program counter
//   imm        in   IMM_W   instruction immediate
//   fwd        in   DATA_W  forwarded ALU result
//   flush      in   1       synchronous flush; empties the buffer
//   out_valid  out  1       out_data/out_sel hold a valid operand
//   out_ready  in   1       downstream takes the operand this cycle
//   out_data   out  DATA_W  selected, extended operand
//   out_sel    out  2       sel value captured with out_data
// ---------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 6,
  parameter int IMM_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        sel,
  input  logic              imm_signed,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [PC_W-1:0]   pc,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] fwd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel
);

  // The state encoding is chosen so that bit 0 is out_valid and bit 1 means
  // "skid occupied". Both handshake outputs are therefore plain flop outputs.
  // The code 2'b10 is never entered. If it ever appears, the next edge
  // recovers it to EMPTY.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b01;
  localparam logic [1:0] ST_SKID  = 2'b11;

  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_REG = 2'b01;
  localparam logic [1:0] SEL_IMM = 2'b10;
  localparam logic [1:0] SEL_FWD = 2'b11;

  logic [1:0]        state;
  logic [DATA_W-1:0] skid_data;
  logic [1:0]        skid_sel;

  logic [DATA_W-1:0] pc_ext;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] operand;

  logic accept;
  logic transfer;

  assign out_valid = state[0];
  assign in_ready  = ~state[1];

  assign accept   = in_valid & in_ready;
  assign transfer = out_valid & out_ready;

  // PC extension. An oversized PC is rejected at elaboration time. When the
  // widths match, the PC passes through unchanged, because a zero-width
  // replication would be illegal.
  generate
    if (PC_W > DATA_W) begin : g_pc_too_wide
      $error("alu_operand_stage: PC_W (%0d) must not exceed DATA_W (%0d)", PC_W, DATA_W);
      assign pc_ext = pc[DATA_W-1:0];
    end else if (PC_W == DATA_W) begin : g_pc_same
      assign pc_ext = pc;
    end else begin : g_pc_extend
      assign pc_ext = {{(DATA_W-PC_W){pc[PC_W-1]}}, pc};
    end
  endgenerate

  // Immediate extension. imm_signed selects sign or zero fill, and it only
  // matters when the immediate is narrower than the operand.
  generate
    if (IMM_W > DATA_W) begin : g_imm_too_wide
      $error("alu_operand_stage: IMM_W (%0d) must not exceed DATA_W (%0d)", IMM_W, DATA_W);
      assign imm_ext = imm[DATA_W-1:0];
    end else if (IMM_W == DATA_W) begin : g_imm_same
      assign imm_ext = imm;
    end else begin : g_imm_extend
      assign imm_ext = imm_signed ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                                  : {{(DATA_W-IMM_W){1'b0}}, imm};
    end
  endgenerate

  // Source mux, evaluated on the inputs present in the accept cycle.
  always_comb begin
    operand = '0;
    case (sel)
      SEL_PC:  operand = pc_ext;
      SEL_REG: operand = reg_a;
      SEL_IMM: operand = imm_ext;
      SEL_FWD: operand = fwd;
      default: operand = '0;
    endcase
  end

  // Elastic buffer control. Flush overrides every other event and drops any
  // word offered in the same cycle. In SKID, in_ready is low, so no accept can
  // happen there. A transfer simply promotes the skid word to the output
  // register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_EMPTY;
      out_data  <= '0;
      out_sel   <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      out_data  <= '0;
      out_sel   <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_data <= operand;
            out_sel  <= sel;
            state    <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && transfer) begin
            out_data <= operand;
            out_sel  <= sel;
          end else if (accept) begin
            skid_data <= operand;
            skid_sel  <= sel;
            state     <= ST_SKID;
          end else if (transfer) begin
            state <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (transfer) begin
            out_data  <= skid_data;
            out_sel   <= skid_sel;
            skid_data <= '0;
            skid_sel  <= '0;
            state     <= ST_FULL;
          end
        end
        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Purpose:
//   Directed, self-checking bench for alu_operand_stage with the default
//   widths (DATA_W=16, PC_W=6, IMM_W=8). Inputs change on the falling edge.
//   Outputs are sampled on the falling edge after each rising edge. All
//   expected values are hand-computed constants.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic        imm_signed;
  logic [15:0] reg_a;
  logic [5:0]  pc;
  logic [7:0]  imm;
  logic [15:0] fwd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_sel;

  int numVectors;
  int numMiscompares;

  alu_operand_stage #(
    .DATA_W(16),
    .PC_W  (6),
    .IMM_W (8)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .imm_signed(imm_signed),
    .reg_a     (reg_a),
    .pc        (pc),
    .imm       (imm),
    .fwd       (fwd),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  // 10-time-unit clock with rising edges at 5, 15, 25 and so on.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drives every DUT input at once. It is called right after a falling edge.
  task automatic applyStimulus(
    input logic        v,
    input logic [1:0]  s,
    input logic        isgn,
    input logic [15:0] ra,
    input logic [5:0]  p,
    input logic [7:0]  im,
    input logic [15:0] fw,
    input logic        fl,
    input logic        ordy
  );
    in_valid   = v;
    sel        = s;
    imm_signed = isgn;
    reg_a      = ra;
    pc         = p;
    imm        = im;
    fwd        = fw;
    flush      = fl;
    out_ready  = ordy;
  endtask

  // Every comparison goes through this task, which also keeps the counts.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numVectors++;
    if (observed !== expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Moves forward one rising edge and returns at the following falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    numVectors     = 0;
    numMiscompares = 0;
    reset_n        = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 6'h0, 8'h0, 16'h0, 1'b0, 1'b0);

    // Reset state.
    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("rst_out_data",  {16'b0, out_data},  32'h0000);
    checkOutput("rst_out_sel",   {30'b0, out_sel},   32'd0);
    reset_n = 1'b1;

    // PC sign extension: 6'b100001 gives 16'hFFE1.
    applyStimulus(1'b1, 2'b00, 1'b0, 16'h0, 6'b100001, 8'h0, 16'h0, 1'b0, 1'b1);
    step();
    checkOutput("pc_out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("pc_out_data",  {16'b0, out_data},  32'h0000FFE1);
    checkOutput("pc_out_sel",   {30'b0, out_sel},   32'd0);

    // Immediate, signed and then unsigned, back to back.
    applyStimulus(1'b1, 2'b10, 1'b1, 16'h0, 6'h0, 8'h80, 16'h0, 1'b0, 1'b1);
    step();
    checkOutput("imm_s_data", {16'b0, out_data}, 32'h0000FF80);
    checkOutput("imm_s_sel",  {30'b0, out_sel},  32'd2);
    applyStimulus(1'b1, 2'b10, 1'b0, 16'h0, 6'h0, 8'h80, 16'h0, 1'b0, 1'b1);
    step();
    checkOutput("imm_u_data", {16'b0, out_data}, 32'h00000080);
    checkOutput("imm_u_valid", {31'b0, out_valid}, 32'd1);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 6'h0, 8'h0, 16'h0, 1'b0, 1'b1);
    step();
    checkOutput("drain_empty", {31'b0, out_valid}, 32'd0);

    // Skid: two accepts while the downstream is stalled.
    applyStimulus(1'b1, 2'b01, 1'b0, 16'h1234, 6'h0, 8'h0, 16'h0, 1'b0, 1'b0);
    step();
    checkOutput("skid_first", {16'b0, out_data}, 32'h1234);
    applyStimulus(1'b1, 2'b01, 1'b0, 16'h5678, 6'h0, 8'h0, 16'h0, 1'b0, 1'b0);
    step();
    checkOutput("skid_in_ready", {31'b0, in_ready},  32'd0);
    checkOutput("skid_valid",    {31'b0, out_valid}, 32'd1);
    checkOutput("skid_held",     {16'b0, out_data},  32'h1234);
    // A request offered while in SKID must not be taken.
    applyStimulus(1'b1, 2'b11, 1'b0, 16'h9999, 6'h0, 8'h0, 16'h9999, 1'b0, 1'b0);
    step();
    checkOutput("skid_stable_data", {16'b0, out_data}, 32'h1234);
    checkOutput("skid_stable_sel",  {30'b0, out_sel},  32'd1);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 6'h0, 8'h0, 16'h0, 1'b0, 1'b1);
    step();
    checkOutput("skid_second",   {16'b0, out_data}, 32'h5678);
    checkOutput("skid_second_rdy", {31'b0, in_ready}, 32'd1);
    step();
    checkOutput("skid_drained", {31'b0, out_valid}, 32'd0);

    // Streaming: fwd = 1..10, one word per cycle.
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 2'b11, 1'b0, 16'h0, 6'h0, 8'h0, 16'(i), 1'b0, 1'b1);
      step();
      checkOutput($sformatf("stream_data_%0d", i), {16'b0, out_data}, 32'(i));
      checkOutput($sformatf("stream_rdy_%0d", i),  {31'b0, in_ready}, 32'd1);
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 6'h0, 8'h0, 16'h0, 1'b0, 1'b1);
    step();
    checkOutput("stream_empty", {31'b0, out_valid}, 32'd0);

    // Flush in SKID with in_valid high. Both held words and the offer are lost.
    applyStimulus(1'b1, 2'b01, 1'b0, 16'hAAAA, 6'h0, 8'h0, 16'h0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 2'b01, 1'b0, 16'hBBBB, 6'h0, 8'h0, 16'h0, 1'b0, 1'b0);
    step();
    checkOutput("flush_pre_skid", {31'b0, in_ready}, 32'd0);
    applyStimulus(1'b1, 2'b01, 1'b0, 16'hCCCC, 6'h0, 8'h0, 16'h0, 1'b1, 1'b0);
    step();
    checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush_ready", {31'b0, in_ready},  32'd1);
    applyStimulus(1'b0, 2'b00, 1'b0, 16'h0, 6'h0, 8'h0, 16'h0, 1'b0, 1'b1);
    step();
    checkOutput("flush_nothing", {31'b0, out_valid}, 32'd0);

    // Flush in FULL with an accept in the same cycle. The offer is dropped.
    applyStimulus(1'b1, 2'b01, 1'b0, 16'h1111, 6'h0, 8'h0, 16'h0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 2'b01, 1'b0, 16'h2222, 6'h0, 8'h0, 16'h0, 1'b1, 1'b0);
    step();
    checkOutput("flush_full_drop", {31'b0, out_valid}, 32'd0);
    // Positive PC after the flush: 6'h1F gives 16'h001F.
    applyStimulus(1'b1, 2'b00, 1'b0, 16'h0, 6'h1F, 8'h0, 16'h0, 1'b0, 1'b1);
    step();
    checkOutput("post_flush_pc", {16'b0, out_data}, 32'h001F);

    // Reset asserted between edges while in SKID.
    applyStimulus(1'b1, 2'b01, 1'b0, 16'hDEAD, 6'h0, 8'h0, 16'h0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 2'b11, 1'b0, 16'h0, 6'h0, 8'h0, 16'hF00D, 1'b0, 1'b0);
    step();
    checkOutput("pre_rst_skid", {31'b0, in_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async_rst_data",  {16'b0, out_data},  32'h0000);
    checkOutput("async_rst_ready", {31'b0, in_ready},  32'd1);
    checkOutput("async_rst_sel",   {30'b0, out_sel},   32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1'b1, 2'b01, 1'b0, 16'hBEEF, 6'h0, 8'h0, 16'h0, 1'b0, 1'b1);
    step();
    checkOutput("post_rst_accept", {16'b0, out_data}, 32'hBEEF);
    checkOutput("post_rst_valid",  {31'b0, out_valid}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
